// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// The slave modport is the subtractor itself, and the master modport is whoever feeds it.
interface serial_subtractor_if #(
    parameter int WIDTH = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             busy;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, busy
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, busy
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor diff = a - b - bin, one bit per clock, LSB first.
// Latency: out_valid rises WIDTH edges after the acceptance edge; one op per WIDTH+2 cycles.
// Backpressure: the result holds in DONE until out_ready; operands are accepted only in IDLE.
module serial_subtractor #(
    parameter  int WIDTH = 3,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_subtractor_if.slave io
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] diff_r;
    logic [WIDTH-1:0] diff_shift;
    logic [CNT_W-1:0] cnt;
    logic             br;
    logic             br_nxt;
    logic             bout_r;
    logic             d;
    logic             last;

    // Single full-subtractor cell working on the current LSBs.
    assign d      = a_sh[0] ^ b_sh[0] ^ br;
    assign br_nxt = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    assign last   = (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        diff_shift            = diff_r >> 1;
        diff_shift[WIDTH-1]   = d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (io.in_valid)  state_nxt = RUN;
            RUN:     if (last)         state_nxt = DONE;
            DONE:    if (io.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff_r <= '0;
            bout_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (io.in_valid) begin
                        a_sh   <= io.a;
                        b_sh   <= io.b;
                        br     <= io.bin;
                        cnt    <= '0;
                        diff_r <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    br     <= br_nxt;
                    diff_r <= diff_shift;
                    cnt    <= cnt + CNT_W'(1);
                    // The borrow out of the MSB cell is the final borrow-out.
                    if (last) bout_r <= br_nxt;
                end
                default: ;
            endcase
        end
    end

    assign io.in_ready  = (state == IDLE);
    assign io.out_valid = (state == DONE);
    assign io.busy      = (state == RUN);
    assign io.diff      = diff_r;
    assign io.bout      = bout_r;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive checks of serial_subtractor at WIDTH=3.
module tb_serial_subtractor;
    localparam int W = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    serial_subtractor_if #(.WIDTH(W)) sif ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (sif.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] diff;
        logic         bout;
    } vec_t;

    vec_t vecs[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Wait for out_valid, scrambling the operand inputs meanwhile; returns edges waited.
    task automatic wait_result(input bit scramble, output int lat);
        lat = 0;
        while (!sif.out_valid && lat < 20) begin
            if (scramble) begin
                sif.a   = W'($urandom);
                sif.b   = W'($urandom);
                sif.bin = 1'($urandom);
            end
            step();
            lat++;
        end
    endtask

    task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bin, input logic [W-1:0] ed, input logic eb);
        int lat;
        chk({nm, ".in_ready_pre"}, 32'(sif.in_ready), 1);
        sif.a = a; sif.b = b; sif.bin = bin; sif.in_valid = 1'b1; sif.out_ready = 1'b1;
        step();
        sif.in_valid = 1'b0;
        chk({nm, ".busy"}, 32'(sif.busy), 1);
        wait_result(1'b1, lat);
        chk({nm, ".latency"}, 32'(lat), W);
        chk({nm, ".diff"}, 32'(sif.diff), 32'(ed));
        chk({nm, ".bout"}, 32'(sif.bout), 32'(eb));
        chk({nm, ".in_ready_done"}, 32'(sif.in_ready), 0);
        step();
        chk({nm, ".in_ready_post"}, 32'(sif.in_ready), 1);
        chk({nm, ".out_valid_post"}, 32'(sif.out_valid), 0);
    endtask

    initial begin
        int lat;
        int last_acc;
        logic [W-1:0] ea;
        logic [W-1:0] eb_;
        logic         ebin;
        logic [W:0]   sum;
        logic [W:0]   ref_d;

        vecs[0] = '{a: 3'd5, b: 3'd3, bin: 1'b0, diff: 3'd2, bout: 1'b0};
        vecs[1] = '{a: 3'd7, b: 3'd0, bin: 1'b0, diff: 3'd7, bout: 1'b0};
        vecs[2] = '{a: 3'd6, b: 3'd1, bin: 1'b0, diff: 3'd5, bout: 1'b0};
        vecs[3] = '{a: 3'd0, b: 3'd0, bin: 1'b1, diff: 3'd7, bout: 1'b1};
        vecs[4] = '{a: 3'd7, b: 3'd7, bin: 1'b1, diff: 3'd7, bout: 1'b1};
        vecs[5] = '{a: 3'd4, b: 3'd1, bin: 1'b0, diff: 3'd3, bout: 1'b0};
        vecs[6] = '{a: 3'd3, b: 3'd5, bin: 1'b0, diff: 3'd6, bout: 1'b1};

        sif.in_valid = 1'b0; sif.out_ready = 1'b0;
        sif.a = '0; sif.b = '0; sif.bin = 1'b0;
        step(); step();
        chk("rst.in_ready", 32'(sif.in_ready), 1);
        chk("rst.out_valid", 32'(sif.out_valid), 0);
        chk("rst.busy", 32'(sif.busy), 0);
        chk("rst.diff", 32'(sif.diff), 0);
        chk("rst.bout", 32'(sif.bout), 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin,
                   vecs[i].diff, vecs[i].bout);
        end

        // Backpressure: hold the result for 5 cycles.
        sif.a = 3'd6; sif.b = 3'd1; sif.bin = 1'b0; sif.in_valid = 1'b1; sif.out_ready = 1'b0;
        step();
        sif.in_valid = 1'b0;
        wait_result(1'b0, lat);
        chk("bp.latency", 32'(lat), W);
        for (int k = 0; k < 5; k++) begin
            chk("bp.out_valid", 32'(sif.out_valid), 1);
            chk("bp.diff", 32'(sif.diff), 5);
            chk("bp.bout", 32'(sif.bout), 0);
            chk("bp.in_ready", 32'(sif.in_ready), 0);
            step();
        end
        sif.out_ready = 1'b1;
        step();
        chk("bp.release_in_ready", 32'(sif.in_ready), 1);
        chk("bp.release_out_valid", 32'(sif.out_valid), 0);

        // Leave a nonzero result held, then reset during the 2nd RUN cycle.
        run_op("pre_rst", 3'd3, 3'd5, 1'b0, 3'd6, 1'b1);
        sif.a = 3'd5; sif.b = 3'd6; sif.bin = 1'b1; sif.in_valid = 1'b1;
        step();
        sif.in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst.in_ready", 32'(sif.in_ready), 1);
        chk("midrst.out_valid", 32'(sif.out_valid), 0);
        chk("midrst.busy", 32'(sif.busy), 0);
        chk("midrst.diff", 32'(sif.diff), 0);
        chk("midrst.bout", 32'(sif.bout), 0);
        run_op("post_rst", 3'd4, 3'd1, 1'b0, 3'd3, 1'b0);

        // Exhaustive back-to-back with in_valid held high.
        sif.out_ready = 1'b1;
        sif.in_valid  = 1'b1;
        last_acc = 0;
        for (int i = 0; i < 128; i++) begin
            ea   = W'(i >> 4);
            eb_  = W'(i >> 1);
            ebin = 1'(i);
            sif.a = ea; sif.b = eb_; sif.bin = ebin;
            step();
            if (i > 0) chk("exh.spacing", 32'(cyc - last_acc), 5);
            last_acc = cyc;
            wait_result(1'b0, lat);
            chk("exh.latency", 32'(lat), W);
            ref_d = {1'b0, ea} - {1'b0, eb_} - {{W{1'b0}}, ebin};
            chk($sformatf("exh.diff a=%0d b=%0d bin=%0d", ea, eb_, ebin), 32'(sif.diff), 32'(ref_d[W-1:0]));
            chk($sformatf("exh.bout a=%0d b=%0d bin=%0d", ea, eb_, ebin), 32'(sif.bout), 32'(ref_d[W]));
            sum = {1'b0, sif.diff} + {1'b0, eb_} + {{W{1'b0}}, ebin};
            chk("exh.roundtrip", 32'(sum), 32'({sif.bout, ea}));
            step();
        end
        sif.in_valid = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Multi-cycle bit-serial subtractor: D = A − B − bin, where A and B are WIDTH bits wide. It is the inverse operation of the team's combinational WIDTH-bit ripple adder with carry-in.
- It processes one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow.
- Valid/ready handshakes on both the operand side and the result side.
- Sits after the adder datapath to recover operands, or to check sums in self-test loops.

Parameters:
WIDTH, 3, operand and difference width in bits (must be ≥1).
CNT_W, $clog2(WIDTH+1), bit-counter width (derived; do not override).

Ports:
clk  input  1  single clock; all state changes on the rising edge.
rst_n  input  1  synchronous active-low reset.
in_valid  input  1  operands presented.
in_ready  output  1  block can accept operands.
a  input  WIDTH  minuend.
b  input  WIDTH  subtrahend.
bin  input  1  borrow-in.
out_valid  output  1  result available.
out_ready  input  1  downstream accepts result.
diff  output  WIDTH  (a − b − bin) mod 2^WIDTH.
bout  output  1  borrow-out: 1 iff a < b + bin (unsigned).
busy  output  1  high in RUN state.

Behaviour:
- Reset (rst_n sampled low at a rising edge): state=IDLE, in_ready=1, out_valid=0, busy=0, diff=0, bout=0, counter=0, shift registers=0. Reset overrides all other activity, including mid-RUN and DONE; any in-flight result is discarded.
- State IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: load a_sh←a, b_sh←b, br←bin, counter←0, diff cleared, then go to RUN.
  - a, b and bin are not sampled at any other time.
- State RUN (in_ready=0, busy=1), at each edge:
  - d = a_sh[0] ^ b_sh[0] ^ br
  - br ← (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br)
  - d is shifted into the diff MSB; a_sh and b_sh shift right; counter increments.
  - When counter reaches WIDTH−1 on this edge, go to DONE. The final br becomes bout, and diff holds the full result LSB-aligned.
- State DONE:
  - out_valid=1; diff and bout are stable and held.
  - On an edge with out_ready=1: go to IDLE and drop out_valid. The held diff/bout values remain visible but are don't-care.
  - out_ready=0 holds indefinitely.
- Latency and throughput:
  - Acceptance edge → out_valid high after exactly WIDTH further edges.
  - No same-cycle re-accept in DONE. Maximum throughput is one operation per WIDTH+2 cycles with out_ready tied high.
- out_valid and in_ready are never both high.
- WIDTH=1: RUN lasts exactly one edge.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.
- No combinational path from any input to any output. All outputs are registered or decoded from the state register.

Test Plan:
- WIDTH=3, a=5, b=3, bin=0, out_ready=1 → out_valid exactly 3 edges after acceptance; diff=2, bout=0.
- a=3, b=5, bin=0 → diff=6, bout=1. Then a=0, b=0, bin=1 → diff=7, bout=1. Then a=7, b=7, bin=1 → diff=7, bout=1. Then a=7, b=0, bin=0 → diff=7, bout=0.
- Backpressure: result a=6, b=1 with out_ready=0 for 5 cycles → out_valid stays 1 with diff=5, bout=0 stable; in_ready=0 throughout. Release out_ready → IDLE next edge, in_ready=1.
- Reset mid-operation: rst_n low for one edge during the 2nd RUN cycle → next cycle state IDLE, in_ready=1, out_valid=0, diff=0, bout=0. A subsequent a=4, b=1 gives diff=3, bout=0 with normal latency.
- Operand isolation: change a, b and bin randomly while in RUN → result reflects only the values sampled at acceptance.
- Exhaustive: all 2^(2·3+1)=128 combinations, back-to-back with in_valid held high → each diff and bout matches (a−b−bin) mod 8 and the borrow. Adder round-trip: adder(diff, b, bin) equals {bout, a}. Accepts are spaced 5 cycles apart.
